csi2_window_packer: RTL

Downstream stage of the MIPI CSI-2 RX decoder, in the read-clock domain. It consumes the decoder's byte-wide pixel stream and its frame and line markers. It crops a programmable rectangular window and packs the kept 8-bit pixels little-endian into 32-bit words. The words go through a small tagged FIFO to a valid/ready master, typically the frame-buffer DMA on the RISC-V system bus.

---
 rtl/csi2_window_packer_if.sv | 19 +
 rtl/csi2_window_packer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/csi2_window_packer_if.sv
// Output word stream of csi2_window_packer: FIFO head, its frame/row tags and the consumer handshake.
interface csi2_window_packer_if;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic        sof_o;
  logic        eol_o;
  logic        eof_o;

  modport master (
    output word_o, word_valid_o, sof_o, eol_o, eof_o,
    input  word_ready_i
  );

  modport slave (
    input  word_o, word_valid_o, sof_o, eol_o, eof_o,
    output word_ready_i
  );
endinterface

// File: rtl/csi2_window_packer.sv
// Crops a window from the CSI-2 decoder pixel stream, packs kept bytes little-endian into 32-bit
// words and queues them with sof/eol/eof tags. Optional macro CSI2_WIN_DECIMATE_EN adds 2x2 decimation.
//
// state  | meaning
// IDLE   | waiting for frame_start_i with enable_i=1; pixels and other markers ignored
// ACTIVE | capturing the current frame into the packer
module csi2_window_packer #(
  parameter int g_FIFO_DEPTH = 16,
  parameter int g_COORD_W    = 11
) (
  input  logic                 READ_CLOCK_I,
  input  logic                 RESET_n_I,
  input  logic                 enable_i,
  input  logic [7:0]           data_in_i,
  input  logic                 pixel_valid_i,
  input  logic                 frame_start_i,
  input  logic                 frame_end_i,
  input  logic                 line_start_i,
  input  logic                 line_end_i,
  input  logic [g_COORD_W-1:0] win_x_i,
  input  logic [g_COORD_W-1:0] win_y_i,
  input  logic [g_COORD_W-1:0] win_w_i,
  input  logic [g_COORD_W-1:0] win_h_i,
  csi2_window_packer_if.master out_if,
  output logic                 overflow_o,
  output logic                 busy_o
);

  localparam int LP_AW = $clog2(g_FIFO_DEPTH);
  localparam int LP_CW = g_COORD_W;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]       r_state;
  logic [LP_CW-1:0] r_win_x, r_win_y, r_win_w, r_win_h;
  logic [LP_CW-1:0] r_x, r_y;
  logic [23:0]      r_pack;
  logic [1:0]       r_cnt;
  logic             r_sof_arm;
  logic             r_push_v;
  logic [31:0]      r_push_data;
  logic             r_push_sof, r_push_eol, r_push_eof;
  logic [34:0]      r_mem [g_FIFO_DEPTH];
  logic [LP_AW:0]   r_wr_ptr, r_rd_ptr;
  logic             r_overflow;

  logic             w_active, w_fs_acc, w_run;
  logic [LP_CW-1:0] w_x_cur;
  logic [LP_CW:0]   w_x_ext, w_y_ext, w_x_end, w_y_end;
  logic             w_in_x, w_in_y, w_keep, w_last_x, w_last_y;
  logic [31:0]      w_word;
  logic [2:0]       w_cnt_new;
  logic             w_eol, w_eof, w_push;
  logic [LP_AW:0]   w_count;
  logic             w_empty, w_full, w_pop, w_wr;
  logic [34:0]      w_head;

  assign w_active = (r_state == ST_ACTIVE);
  assign w_fs_acc = frame_start_i & enable_i;
  assign w_run    = w_active & ~frame_start_i;
  assign w_x_cur  = line_start_i ? '0 : r_x;

  // Window bounds are evaluated one bit wider so origin+size never wraps.
  assign w_x_ext = {1'b0, w_x_cur};
  assign w_y_ext = {1'b0, r_y};
  assign w_x_end = {1'b0, r_win_x} + {1'b0, r_win_w};
  assign w_y_end = {1'b0, r_win_y} + {1'b0, r_win_h};
  assign w_in_x  = (w_x_ext >= {1'b0, r_win_x}) && (w_x_ext < w_x_end);
  assign w_in_y  = (w_y_ext >= {1'b0, r_win_y}) && (w_y_ext < w_y_end);

`ifdef CSI2_WIN_DECIMATE_EN
  // Even relative offset <=> same LSB as the window origin.
  assign w_keep   = w_run & pixel_valid_i & w_in_x & w_in_y
                    & ~(w_x_cur[0] ^ r_win_x[0]) & ~(r_y[0] ^ r_win_y[0]);
  assign w_last_x = (w_x_ext + (LP_CW+1)'(2)) >= w_x_end;
  assign w_last_y = (w_y_ext + (LP_CW+1)'(2)) >= w_y_end;
`else
  assign w_keep   = w_run & pixel_valid_i & w_in_x & w_in_y;
  assign w_last_x = (w_x_ext + (LP_CW+1)'(1)) == w_x_end;
  assign w_last_y = (w_y_ext + (LP_CW+1)'(1)) == w_y_end;
`endif

  always_comb begin
    w_word    = {8'h00, r_pack};
    w_cnt_new = {1'b0, r_cnt};
    if (w_keep) begin
      case (r_cnt)
        2'd0:    w_word[7:0]   = data_in_i;
        2'd1:    w_word[15:8]  = data_in_i;
        2'd2:    w_word[23:16] = data_in_i;
        default: w_word[31:24] = data_in_i;
      endcase
      w_cnt_new = {1'b0, r_cnt} + 3'd1;
    end
  end

  assign w_eol  = (w_keep & w_last_x) | line_end_i | frame_end_i;
  assign w_eof  = w_eol & (w_last_y | frame_end_i);
  assign w_push = w_run & (w_cnt_new != 3'd0) & ((w_cnt_new == 3'd4) | w_eol);

  always_ff @(posedge READ_CLOCK_I or negedge RESET_n_I) begin
    if (!RESET_n_I) begin
      r_state     <= ST_IDLE;
      r_win_x     <= '0;
      r_win_y     <= '0;
      r_win_w     <= '0;
      r_win_h     <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_pack      <= '0;
      r_cnt       <= '0;
      r_sof_arm   <= 1'b0;
      r_push_v    <= 1'b0;
      r_push_data <= '0;
      r_push_sof  <= 1'b0;
      r_push_eol  <= 1'b0;
      r_push_eof  <= 1'b0;
    end else begin
      r_push_v    <= w_push;
      r_push_data <= w_word;
      r_push_sof  <= r_sof_arm;
      r_push_eol  <= w_eol;
      r_push_eof  <= w_eof;
      if (frame_start_i) begin
        r_state <= w_fs_acc ? ST_ACTIVE : ST_IDLE;
        r_pack  <= '0;
        r_cnt   <= '0;
        r_x     <= '0;
        r_y     <= '0;
        if (w_fs_acc) begin
          r_win_x   <= win_x_i;
          r_win_y   <= win_y_i;
          r_win_w   <= win_w_i;
          r_win_h   <= win_h_i;
          r_sof_arm <= 1'b1;
        end
      end else if (w_active) begin
        if (pixel_valid_i && (w_x_cur != '1))
          r_x <= w_x_cur + LP_CW'(1);
        else
          r_x <= w_x_cur;
        if (line_end_i && (r_y != '1))
          r_y <= r_y + LP_CW'(1);
        if (w_push) begin
          r_pack    <= '0;
          r_cnt     <= '0;
          r_sof_arm <= 1'b0;
        end else if (w_keep) begin
          r_pack <= w_word[23:0];
          r_cnt  <= w_cnt_new[1:0];
        end
        if (frame_end_i)
          r_state <= ST_IDLE;
      end
    end
  end

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == (LP_AW+1)'(g_FIFO_DEPTH));
  assign w_pop   = ~w_empty & out_if.word_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_wr    = r_push_v & (~w_full | w_pop);

  always_ff @(posedge READ_CLOCK_I) begin
    if (w_wr)
      r_mem[r_wr_ptr[LP_AW-1:0]] <= {r_push_eof, r_push_eol, r_push_sof, r_push_data};
  end

  always_ff @(posedge READ_CLOCK_I or negedge RESET_n_I) begin
    if (!RESET_n_I) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + (LP_AW+1)'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + (LP_AW+1)'(1);
      if (r_push_v & ~w_wr)
        r_overflow <= 1'b1;
      else if (w_fs_acc)
        r_overflow <= 1'b0;
    end
  end

  assign w_head              = r_mem[r_rd_ptr[LP_AW-1:0]];
  assign out_if.word_o       = w_empty ? 32'h0 : w_head[31:0];
  assign out_if.sof_o        = ~w_empty & w_head[32];
  assign out_if.eol_o        = ~w_empty & w_head[33];
  assign out_if.eof_o        = ~w_empty & w_head[34];
  assign out_if.word_valid_o = ~w_empty;
  assign overflow_o          = r_overflow;
  assign busy_o              = w_active;

endmodule
